// File: rtl/relu_maxpool_pkg.sv
// rtl/relu_maxpool_pkg.sv - shared constants, sample type and pooling floor for relu_maxpool_29_2_16
// Pooling floor selected by RELU_MAXPOOL_RELU_EN (defined: 0, fused ReLU; undefined: most negative value).
package relu_maxpool_pkg;

   localparam int L            = 29;
   localparam int W            = 2;
   localparam int T            = 16;
   localparam int OUTS_PER_VEC = L / W;
   localparam int TAIL         = L % W;
   localparam int POOL_LEN     = OUTS_PER_VEC * W;
   localparam int E_W          = $clog2(L);
   localparam int W_W          = (W > 1) ? $clog2(W) : 1;

   typedef logic signed [T-1:0] sample_t;

   function automatic sample_t pool_floor(input int unsigned t);
      sample_t f;
`ifdef RELU_MAXPOOL_RELU_EN
      f = sample_t'(t) & '0;
`else
      f = sample_t'(1) << (t - 1);
`endif
      return f;
   endfunction

endpackage

// File: rtl/relu_maxpool_29_2_16_pool_out_reg.sv
// rtl/relu_maxpool_29_2_16_pool_out_reg.sv - single-entry output register with valid/ready hold
// Upstream is stalled while a result sits undrained, so a load never overwrites a held value.
module pool_out_reg
   import relu_maxpool_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    load_i,
   input  sample_t data_i,
   input  logic    y_ready_i,
   output sample_t y_data_o,
   output logic    y_valid_o,
   output logic    x_ready_o
);

   sample_t y_data_q, y_data_d;
   logic    y_valid_q, y_valid_d;

   always_comb begin
      y_data_d  = y_data_q;
      y_valid_d = y_valid_q;
      if (load_i) begin
         y_data_d  = data_i;
         y_valid_d = 1'b1;
      end else if (y_valid_q && y_ready_i) begin
         y_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y_data_q  <= '0;
         y_valid_q <= 1'b0;
      end else begin
         y_data_q  <= y_data_d;
         y_valid_q <= y_valid_d;
      end
   end

   assign y_data_o  = y_data_q;
   assign y_valid_o = y_valid_q;
   assign x_ready_o = !(y_valid_q && !y_ready_i);

endmodule

// File: rtl/relu_maxpool_29_2_16.sv
// rtl/relu_maxpool_29_2_16.sv - streaming ReLU + 1-D max-pool (window 2, stride 2) over 29-sample vectors
// Floor of the running max comes from RELU_MAXPOOL_RELU_EN via relu_maxpool_pkg::pool_floor.
module relu_maxpool_29_2_16
   import relu_maxpool_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  sample_t x_data,
   input  logic    x_valid,
   output logic    x_ready,
   output sample_t y_data,
   output logic    y_valid,
   input  logic    y_ready
);

   localparam sample_t FLOOR = pool_floor(T);

   logic [E_W-1:0] e_q, e_d;
   logic [W_W-1:0] w_q, w_d;
   sample_t        m_q, m_d;
   sample_t        win_max;
   logic           accept;
   logic           load;

   assign accept  = x_valid && x_ready;
   assign win_max = (x_data > m_q) ? x_data : m_q;

   always_comb begin
      e_d  = e_q;
      w_d  = w_q;
      m_d  = m_q;
      load = 1'b0;
      if (accept) begin
         if (e_q < E_W'(POOL_LEN)) begin
            if (w_q == W_W'(W - 1)) begin
               load = 1'b1;
               w_d  = '0;
               m_d  = FLOOR;
            end else begin
               w_d = w_q + 1'b1;
               m_d = win_max;
            end
         end
         // Tail samples fall through untouched; the vector wrap forces a clean window.
         if (e_q == E_W'(L - 1)) begin
            e_d = '0;
            w_d = '0;
            m_d = FLOOR;
         end else begin
            e_d = e_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q <= '0;
         w_q <= '0;
         m_q <= FLOOR;
      end else begin
         e_q <= e_d;
         w_q <= w_d;
         m_q <= m_d;
      end
   end

   pool_out_reg u_out (
      .clk       (clk),
      .reset     (reset),
      .load_i    (load),
      .data_i    (win_max),
      .y_ready_i (y_ready),
      .y_data_o  (y_data),
      .y_valid_o (y_valid),
      .x_ready_o (x_ready)
   );

endmodule

// File: tb/tb_relu_maxpool_29_2_16.sv
// tb/tb_relu_maxpool_29_2_16.sv - randomized self-checking bench for relu_maxpool_29_2_16
module tb_relu_maxpool_29_2_16;

   typedef logic [15:0] vec_t [29];

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] x_data = '0;
   logic        x_valid = 1'b0;
   logic        x_ready;
   logic [15:0] y_data;
   logic        y_valid;
   logic        y_ready = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;
   int acc_cnt  = 0;
   int out_cnt  = 0;
   bit rnd_ready = 1'b0;
   bit ready_val = 1'b1;
   bit held = 1'b0;
   logic [15:0] held_val;
   logic signed [15:0] vec_buf [29];
   logic [15:0] exp_q [$];

`ifdef RELU_MAXPOOL_RELU_EN
   localparam logic signed [15:0] FLOOR = 16'sh0000;
`else
   localparam logic signed [15:0] FLOOR = 16'sh8000;
`endif

   relu_maxpool_29_2_16 dut (
      .clk     (clk),
      .reset   (reset),
      .x_data  (x_data),
      .x_valid (x_valid),
      .x_ready (x_ready),
      .y_data  (y_data),
      .y_valid (y_valid),
      .y_ready (y_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic signed [15:0] smax(input logic signed [15:0] a, input logic signed [15:0] b);
      return (a > b) ? a : b;
   endfunction

   // Reference: each vector is 29 samples; pairs (0,1),(2,3)..(26,27) each yield max(floor, a, b).
   task automatic model_accept(input logic [15:0] x);
      int idx;
      idx = acc_cnt % 29;
      vec_buf[idx] = x;
      if (idx < 28 && (idx % 2) == 1)
         exp_q.push_back(smax(FLOOR, smax(vec_buf[idx-1], vec_buf[idx])));
      acc_cnt++;
   endtask

   task automatic send_vec(input vec_t v, input int n, input int vpct);
      bit ok;
      int budget;
      for (int i = 0; i < n; i++) begin
         while ($urandom_range(99) >= vpct) begin
            x_valid = 1'b0;
            @(posedge clk); #1;
         end
         x_data  = v[i];
         x_valid = 1'b1;
         budget  = 0;
         ok      = 1'b0;
         while (!ok && budget < 500) begin
            @(negedge clk);
            ok = x_ready;
            budget++;
            if (!ok) begin
               @(posedge clk); #1;
            end
         end
         if (!ok) begin
            check("accept_timeout", 32'(ok), 32'd1);
            x_valid = 1'b0;
            return;
         end
         model_accept(v[i]);
         @(posedge clk); #1;
      end
      x_valid = 1'b0;
   endtask

   task automatic drain();
      int b = 0;
      while ((exp_q.size() != 0 || y_valid) && b < 2000) begin
         @(posedge clk); #1;
         b++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         y_ready = rnd_ready ? ($urandom_range(99) < 75) : ready_val;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         held = 1'b0;
      end else begin
         if (y_valid && held) check("hold_stable", 32'(y_data), 32'(held_val));
         if (y_valid && y_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 32'(exp_q.size()), 32'd1);
            end else begin
               check("y_data", 32'(y_data), 32'(exp_q.pop_front()));
               out_cnt++;
            end
            held = 1'b0;
         end else if (y_valid) begin
            held     = 1'b1;
            held_val = y_data;
         end else begin
            held = 1'b0;
         end
      end
   end

   initial begin
      vec_t v;
      int   base;

      #1;
      check("reset_y_valid", 32'(y_valid), 32'd0);
      check("reset_y_data", 32'(y_data), 32'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      check("idle_x_ready", 32'(x_ready), 32'd1);

      // Two ramps back to back at full rate.
      for (int i = 0; i < 29; i++) v[i] = 16'(i);
      base = out_cnt;
      send_vec(v, 29, 100);
      send_vec(v, 29, 100);
      drain();
      check("ramp_outputs", 32'(out_cnt - base), 32'd28);

      // Constant negative vector.
      for (int i = 0; i < 29; i++) v[i] = 16'hFFFB;
      send_vec(v, 29, 100);
      drain();

      // Extremes in the first two windows.
      for (int i = 0; i < 29; i++) v[i] = 16'($urandom);
      v[0] = 16'h8000; v[1] = 16'h7FFF; v[2] = 16'h8000; v[3] = 16'h8000;
      send_vec(v, 29, 100);
      drain();

      // Backpressure: hold y_ready low for 10 cycles once the first result appears.
      for (int i = 0; i < 29; i++) v[i] = 16'(i);
      ready_val = 1'b0;
      fork
         send_vec(v, 29, 100);
         begin
            int b = 0;
            while (!y_valid && b < 100) begin
               @(negedge clk);
               b++;
            end
            check("bp_y_valid", 32'(y_valid), 32'd1);
            repeat (10) begin
               @(negedge clk);
               check("bp_x_ready", 32'(x_ready), 32'd0);
               check("bp_y_data", 32'(y_data), 32'h0001);
            end
            ready_val = 1'b1;
         end
      join
      drain();

      // Reset mid-vector after 7 accepts, then a fresh ramp.
      send_vec(v, 7, 100);
      reset = 1'b1;
      #1;
      check("midreset_y_valid", 32'(y_valid), 32'd0);
      exp_q.delete();
      acc_cnt = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      base = out_cnt;
      send_vec(v, 29, 100);
      drain();
      check("post_reset_outputs", 32'(out_cnt - base), 32'd14);

      // Random traffic on both sides.
      rnd_ready = 1'b1;
      base = out_cnt;
      for (int k = 0; k < 312; k++) begin
         for (int i = 0; i < 29; i++) v[i] = 16'($urandom);
         send_vec(v, 29, 75);
      end
      rnd_ready = 1'b0;
      drain();
      check("random_outputs", 32'(out_cnt - base), 32'd4368);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
